// File: rtl/adc_offset_cal_ctrl_if.sv
// Handshake and data bundle for the ADC offset calibration sequencer.
// master drives start and core words; slave is the sequencer.
interface adc_offset_cal_ctrl_if #(
    parameter int unsigned ADC_DATA_WIDTH = 8,
    parameter int unsigned LOG2_LANES     = 3
);
    localparam int unsigned WORD_W = ADC_DATA_WIDTH << LOG2_LANES;

    logic                             start_i;
    logic        [WORD_W-1:0]         adc_signed_all_bit_i_A;
    logic        [WORD_W-1:0]         adc_signed_all_bit_i_B;
    logic        [WORD_W-1:0]         adc_signed_all_bit_i_C;
    logic        [WORD_W-1:0]         adc_signed_all_bit_i_D;
    logic signed [ADC_DATA_WIDTH-1:0] offset_o_A;
    logic signed [ADC_DATA_WIDTH-1:0] offset_o_B;
    logic signed [ADC_DATA_WIDTH-1:0] offset_o_C;
    logic signed [ADC_DATA_WIDTH-1:0] offset_o_D;
    logic                             busy_o;
    logic                             done_o;
    logic        [1:0]                core_sel_o;

    modport master (
        output start_i,
        output adc_signed_all_bit_i_A, adc_signed_all_bit_i_B,
        output adc_signed_all_bit_i_C, adc_signed_all_bit_i_D,
        input  offset_o_A, offset_o_B, offset_o_C, offset_o_D,
        input  busy_o, done_o, core_sel_o
    );

    modport slave (
        input  start_i,
        input  adc_signed_all_bit_i_A, adc_signed_all_bit_i_B,
        input  adc_signed_all_bit_i_C, adc_signed_all_bit_i_D,
        output offset_o_A, offset_o_B, offset_o_C, offset_o_D,
        output busy_o, done_o, core_sel_o
    );
endinterface

// File: rtl/adc_offset_cal_ctrl.sv
// Round-robin DC-offset measurement over ADC cores A-D; stores the floor mean per core.
// Define ADC_OFFSET_CAL_AUTO_EN for continuous re-measurement after each pass.
module adc_offset_cal_ctrl #(
    parameter int unsigned ADC_DATA_WIDTH = 8,
    parameter int unsigned LOG2_LANES     = 3,
    parameter int unsigned LOG2_FRAMES    = 10,
    parameter int unsigned SETTLE_CYCLES  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    adc_offset_cal_ctrl_if.slave  bus
);
    localparam int unsigned LANES  = 1 << LOG2_LANES;
    localparam int unsigned WORD_W = ADC_DATA_WIDTH * LANES;
    localparam int unsigned SUM_W  = ADC_DATA_WIDTH + LOG2_LANES;
    localparam int unsigned ACC_W  = SUM_W + LOG2_FRAMES;
    localparam int unsigned SHIFT  = LOG2_LANES + LOG2_FRAMES;
    localparam int unsigned SET_W  = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned CNT_W  = (SET_W > LOG2_FRAMES + 1) ? SET_W : LOG2_FRAMES + 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] FRAME_LAST  = CNT_W'((1 << LOG2_FRAMES) - 1);

    typedef enum logic [2:0] {StIdle, StSettle, StAccum, StStore, StDone} state_e;

    state_e                      state_q, state_d;
    logic        [CNT_W-1:0]     cnt_q, cnt_d;
    logic signed [ACC_W-1:0]     acc_q, acc_d;
    logic        [1:0]           sel_q, sel_d;
    logic signed [ADC_DATA_WIDTH-1:0] off_q [4];
    logic                        store_en;
    logic                        launch;
    logic        [WORD_W-1:0]    word_sel;
    logic signed [ADC_DATA_WIDTH-1:0] lane;
    logic signed [SUM_W-1:0]     lane_sum;
    logic signed [ACC_W-1:0]     acc_shr;

`ifdef ADC_OFFSET_CAL_AUTO_EN
    logic wait_q, wait_d;
    assign launch = bus.start_i | (wait_q & (cnt_q == FRAME_LAST));
`else
    assign launch = bus.start_i;
`endif

    always_comb begin
        unique case (sel_q)
            2'd0: word_sel = bus.adc_signed_all_bit_i_A;
            2'd1: word_sel = bus.adc_signed_all_bit_i_B;
            2'd2: word_sel = bus.adc_signed_all_bit_i_C;
            2'd3: word_sel = bus.adc_signed_all_bit_i_D;
        endcase
    end

    // Each lane is sign-extended to the full sum width before adding.
    always_comb begin
        lane_sum = '0;
        lane     = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            lane     = word_sel[k*ADC_DATA_WIDTH +: ADC_DATA_WIDTH];
            lane_sum = lane_sum + SUM_W'(lane);
        end
    end

    assign acc_shr = acc_q >>> SHIFT;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        sel_d    = sel_q;
        store_en = 1'b0;
`ifdef ADC_OFFSET_CAL_AUTO_EN
        wait_d   = wait_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (launch) begin
                    state_d = StSettle;
                    sel_d   = '0;
                    cnt_d   = '0;
                    acc_d   = '0;
`ifdef ADC_OFFSET_CAL_AUTO_EN
                    wait_d  = 1'b0;
                end else if (wait_q) begin
                    cnt_d   = cnt_q + 1'b1;
`endif
                end
            end
            StSettle: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = StAccum;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            StAccum: begin
                acc_d = acc_q + ACC_W'(lane_sum);
                if (cnt_q == FRAME_LAST) begin
                    state_d = StStore;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            StStore: begin
                store_en = 1'b1;
                if (sel_q != 2'd3) begin
                    state_d = StSettle;
                    sel_d   = sel_q + 1'b1;
                    acc_d   = '0;
                    cnt_d   = '0;
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
`ifdef ADC_OFFSET_CAL_AUTO_EN
                // The DONE cycle counts as the first cycle of the idle wait.
                wait_d  = 1'b1;
                cnt_d   = CNT_W'(1);
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            acc_q   <= '0;
            sel_q   <= '0;
`ifdef ADC_OFFSET_CAL_AUTO_EN
            wait_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sel_q   <= sel_d;
`ifdef ADC_OFFSET_CAL_AUTO_EN
            wait_q  <= wait_d;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) off_q[i] <= '0;
        end else if (store_en) begin
            off_q[sel_q] <= acc_shr[ADC_DATA_WIDTH-1:0];
        end
    end

    assign bus.offset_o_A = off_q[0];
    assign bus.offset_o_B = off_q[1];
    assign bus.offset_o_C = off_q[2];
    assign bus.offset_o_D = off_q[3];
    assign bus.busy_o     = (state_q != StIdle) && (state_q != StDone);
    assign bus.done_o     = (state_q == StDone);
    assign bus.core_sel_o = sel_q;
endmodule

// File: tb/tb_adc_offset_cal_ctrl.sv
// Scoreboard bench for adc_offset_cal_ctrl: expected offsets are queued at start
// and compared when done_o pulses.
module tb_adc_offset_cal_ctrl;
    localparam int W    = 8;
    localparam int L    = 3;
    localparam int LF   = 4;
    localparam int SC   = 4;
    localparam int PER  = SC + (1 << LF) + 1;
    localparam int CYC  = 4 * PER;
    localparam int WAIT = 1 << LF;
`ifdef ADC_OFFSET_CAL_AUTO_EN
    localparam int SINGLE_RUNS = 2;
`else
    localparam int SINGLE_RUNS = 1;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_q[$];

    always #5 clk = ~clk;

    adc_offset_cal_ctrl_if #(.ADC_DATA_WIDTH(W), .LOG2_LANES(L)) bus ();

    adc_offset_cal_ctrl #(
        .ADC_DATA_WIDTH(W),
        .LOG2_LANES    (L),
        .LOG2_FRAMES   (LF),
        .SETTLE_CYCLES (SC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int lane_val(input int mode, input int core, input int lane,
                                    input int c, input int step_end);
        case (mode)
            0: case (core)
                   0: return 3;
                   1: return -5;
                   2: return 0;
                   default: return 127;
               endcase
            1: return (core == 0) ? lane % 2 : 0;
            2: return (core == 0 && lane % 2 == 0) ? -1 : 0;
            3: return (core == 1) ? ((c <= step_end) ? -128 : 10) : 0;
            default: return ((lane * 7 + core * 11 + c + 62) % 31) - 15;
        endcase
    endfunction

    // Floor mean over the accumulate window of one core.
    function automatic int model_offset(input int mode, input int core, input int step_end,
                                        input int base);
        int sum = 0;
        int c0  = base + core * PER + SC;
        for (int c = c0; c < c0 + (1 << LF); c++)
            for (int k = 0; k < (1 << L); k++) sum += lane_val(mode, core, k, c, step_end);
        return sum >>> (L + LF);
    endfunction

    function automatic int get_off(input int core);
        case (core)
            0: return int'(bus.offset_o_A);
            1: return int'(bus.offset_o_B);
            2: return int'(bus.offset_o_C);
            default: return int'(bus.offset_o_D);
        endcase
    endfunction

    task automatic set_words(input int mode, input int c, input int step_end);
        logic [(W<<L)-1:0] w [4];
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < (1 << L); k++)
                w[i][k*W +: W] = W'(lane_val(mode, i, k, c, step_end));
        bus.adc_signed_all_bit_i_A = w[0];
        bus.adc_signed_all_bit_i_B = w[1];
        bus.adc_signed_all_bit_i_C = w[2];
        bus.adc_signed_all_bit_i_D = w[3];
    endtask

    task automatic check_reset_state(input string name);
        check_val({name, " busy"}, int'(bus.busy_o), 0);
        check_val({name, " done"}, int'(bus.done_o), 0);
        check_val({name, " core_sel"}, int'(bus.core_sel_o), 0);
        for (int i = 0; i < 4; i++)
            check_val($sformatf("%s off%0d", name, i), get_off(i), 0);
    endtask

    // c counts cycles from the edge that accepts start (cycle 0 = first SETTLE).
    task automatic run_cal(input string name, input int mode, input int step_end,
                           input int restart_at, input int rst_at, input int n_cyc,
                           input int n_runs);
        int pulses = 0;
        @(negedge clk);
        bus.start_i = 1'b1;
        set_words(mode, -1, step_end);
        for (int r = 0; r < n_runs; r++)
            for (int i = 0; i < 4; i++)
                exp_q.push_back(model_offset(mode, i, step_end, r * (CYC + WAIT)));
        @(negedge clk);
        bus.start_i = 1'b0;
        for (int c = 0; c < n_cyc; c++) begin
            set_words(mode, c, step_end);
            bus.start_i = (c == restart_at);
            if (c == 0 || c == CYC - 1) check_val({name, " busy_high"}, int'(bus.busy_o), 1);
            if (c == CYC) check_val({name, " busy_low"}, int'(bus.busy_o), 0);
            if (bus.done_o) begin
                check_val({name, " done_cycle"}, c, CYC + pulses * (CYC + WAIT));
                pulses++;
                if (exp_q.size() < 4) begin
                    check_val({name, " sb_depth"}, exp_q.size(), 4);
                end else begin
                    for (int i = 0; i < 4; i++)
                        check_val($sformatf("%s off%0d", name, i), get_off(i), exp_q.pop_front());
                end
            end
            if (c == rst_at) begin
                #2 rst = 1'b1;
                #1 check_reset_state({name, " async_rst"});
                check_val({name, " pulses_before_rst"}, pulses, 0);
                exp_q.delete();
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            @(negedge clk);
        end
        check_val({name, " pulses"}, pulses, n_runs);
        exp_q.delete();
    endtask

    initial begin
        rst         = 1'b1;
        bus.start_i = 1'b0;
        set_words(0, -1, 0);
        repeat (3) @(negedge clk);
        check_reset_state("por");
        rst = 1'b0;

        run_cal("const",       0, 0,  -1, -1, 90,  1);
        run_cal("alt01",       1, 0,  -1, -1, 90,  1);
        run_cal("alt_m1_0",    2, 0,  -1, -1, 90,  1);
        run_cal("settle",      3, 24, -1, -1, 90,  1);
        run_cal("settle_late", 3, 25, -1, -1, 90,  1);
        run_cal("restart_ign", 0, 0,  30, -1, 90,  1);
        run_cal("mid_rst",     4, 0,  -1, 50, 90,  1);
        run_cal("after_rst",   4, 0,  -1, -1, 90,  1);
        run_cal("single",      4, 0,  -1, -1, 200, SINGLE_RUNS);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
